// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, counter width and frame levels.
// The frame constants are common to uart_tx and uart_rx.
package uart_pkg;

    localparam int CNT_W     = 16;
    localparam int IDX_W     = 3;
    localparam int DATA_BITS = 8;

    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        CLEANUP   = 3'd4,
        WAIT_IDLE = 3'd5
    } rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for a single asynchronous input.
// RESET_VAL sets the level both stages take while reset is asserted.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1, LSB first: mid-bit sampling, start-glitch rejection,
// framing-error and break reporting, one-cycle valid pulse per good byte.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 1155
) (
    input  logic       osc_clk,
    input  logic       i_Rst_n,
    input  logic       i_Rx_Serial,
    output logic       o_Rx_DV,
    output logic [7:0] o_Rx_Byte,
    output logic       o_Rx_Active,
    output logic       o_Frame_Err,
    output logic       o_Break
);

    localparam logic [CNT_W-1:0] HALF     = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] LAST     = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    logic r_Rx;

    rx_state_e              state_q, state_d;
    logic [CNT_W-1:0]       cnt_q,   cnt_d;
    logic [IDX_W-1:0]       idx_q,   idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [DATA_BITS-1:0]   byte_q,  byte_d;
    logic                   dv_q,    dv_d;
    logic                   ferr_q,  ferr_d;
    logic                   brk_q,   brk_d;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk_i  (osc_clk),
        .rst_ni (i_Rst_n),
        .d_i    (i_Rx_Serial),
        .q_o    (r_Rx)
    );

    always_ff @(posedge osc_clk) begin
        if (!i_Rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            byte_q  <= '0;
            dv_q    <= 1'b0;
            ferr_q  <= 1'b0;
            brk_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            byte_q  <= byte_d;
            dv_q    <= dv_d;
            ferr_q  <= ferr_d;
            brk_q   <= brk_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        byte_d  = byte_q;
        dv_d    = 1'b0;
        ferr_d  = 1'b0;
        brk_d   = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (r_Rx == START_LEVEL) begin
                    state_d = START;
                end
            end
            START: begin
                // A start bit that is no longer low at mid-bit was a glitch.
                if (cnt_q == HALF) begin
                    cnt_d   = '0;
                    state_d = (r_Rx == START_LEVEL) ? DATA : IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = r_Rx;
                    if (idx_q == LAST_IDX) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == LAST) begin
                    cnt_d = '0;
                    if (r_Rx == STOP_LEVEL) begin
                        byte_d  = shift_q;
                        dv_d    = 1'b1;
                        state_d = CLEANUP;
                    end else begin
                        ferr_d  = 1'b1;
                        brk_d   = (shift_q == '0);
                        state_d = WAIT_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CLEANUP: begin
                state_d = IDLE;
            end
            WAIT_IDLE: begin
                // Hold off until the line returns high so a break cannot retrigger.
                if (r_Rx == STOP_LEVEL) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign o_Rx_DV     = dv_q;
    assign o_Rx_Byte   = byte_q;
    assign o_Frame_Err = ferr_q;
    assign o_Break     = brk_q;
    assign o_Rx_Active = (state_q == START) || (state_q == DATA) || (state_q == STOP);

endmodule

// File: tb/tb_uart_rx.sv
// Randomised scoreboard bench for uart_rx at CLKS_PER_BIT=8: a serial driver
// queues expected events, an independent monitor checks every output pulse.
module tb_uart_rx;

    localparam int CPB  = 8;
    localparam int HALF = CPB / 2;
    // Line change to output pulse: 2 sync edges, 1 detect edge, start check at
    // HALF+1, then 9 whole bit periods to the stop sample (pulse visible after it).
    localparam longint LAT = 3 + 1 + HALF + 9 * CPB;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       dv;
    logic [7:0] rx_byte;
    logic       active;
    logic       ferr;
    logic       brk;

    typedef struct {
        bit         is_fe;
        bit         brk;
        logic [7:0] data;
        longint     cyc;
    } exp_t;

    exp_t       exp_q[$];
    longint     cyc = 0;
    int         n_tests = 0;
    int         n_fail = 0;
    logic [7:0] last_good = 8'h00;

    uart_rx #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .osc_clk     (clk),
        .i_Rst_n     (rst_n),
        .i_Rx_Serial (rx),
        .o_Rx_DV     (dv),
        .o_Rx_Byte   (rx_byte),
        .o_Rx_Active (active),
        .o_Frame_Err (ferr),
        .o_Break     (brk)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: any output pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst_n) begin
            last_good = 8'h00;
        end else if (dv || ferr || brk) begin
            $display("[TB] event cyc=%0d dv=%0b ferr=%0b brk=%0b byte=%02h", cyc, dv, ferr, brk, rx_byte);
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("dv", dv, !e.is_fe);
                check("frame_err", ferr, e.is_fe);
                check("break", brk, e.brk);
                check("latency", cyc, e.cyc);
                check("byte", rx_byte, e.is_fe ? last_good : e.data);
                if (!e.is_fe) last_good = e.data;
            end
        end
    end

    // Drives the first nbits of a frame {stop, data, start}, LSB first.
    task automatic drive_frame(input logic [7:0] b, input bit stop, input int nbits);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            rx = f[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
        rx = 1'b1;
    endtask

    task automatic send(input logic [7:0] b, input bit stop);
        exp_t e;
        e.is_fe = !stop;
        e.brk   = !stop && (b == 8'h00);
        e.data  = b;
        e.cyc   = cyc + LAT;
        exp_q.push_back(e);
        $display("[TB] send byte=%02h stop=%0b", b, stop);
        drive_frame(b, stop, 10);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int   cnt;
        exp_t e;

        repeat (4) @(posedge clk);
        @(negedge clk);
        check("rst_dv", dv, 0);
        check("rst_ferr", ferr, 0);
        check("rst_break", brk, 0);
        check("rst_active", active, 0);
        check("rst_byte", rx_byte, 8'h00);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(5);

        send(8'hA5, 1'b1);
        idle(3);
        send(8'h00, 1'b1);
        send(8'hFF, 1'b1);
        idle(4);

        // Start-bit glitch: short activity, no pulses.
        rx = 1'b0;
        repeat (3) @(posedge clk);
        #1 rx = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (active) cnt++;
        end
        check("glitch_active_bounded", (cnt >= 1 && cnt <= 5), 1);
        @(posedge clk);
        #1;

        send(8'h3C, 1'b0);
        idle(2 * CPB);

        // Held-low break: one error+break, then nothing until release.
        e.is_fe = 1'b1;
        e.brk   = 1'b1;
        e.data  = 8'h00;
        e.cyc   = cyc + LAT;
        exp_q.push_back(e);
        $display("[TB] send break hold=200");
        rx = 1'b0;
        repeat (200) @(posedge clk);
        #1;
        idle(3 * CPB);
        send(8'h5A, 1'b1);
        idle(CPB);

        // Reset in the middle of a frame; the partial byte must vanish.
        $display("[TB] send byte=81 aborted by reset");
        drive_frame(8'h81, 1'b1, 4);
        rx = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_dv", dv, 0);
        check("midrst_ferr", ferr, 0);
        check("midrst_break", brk, 0);
        check("midrst_active", active, 0);
        check("midrst_byte", rx_byte, 8'h00);
        @(posedge clk);
        #1 rx = 1'b1;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(CPB);
        send(8'h42, 1'b1);

        // Random traffic, including bad stops and breaks.
        for (int i = 0; i < 40; i++) begin
            logic [7:0] b;
            bit         stop;
            b    = 8'($urandom);
            stop = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 9) == 0) b = 8'h00;
            send(b, stop);
            if (stop) idle($urandom_range(0, 12));
            else      idle($urandom_range(2 * CPB, 3 * CPB));
        end

        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        check("drain_queue", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
